// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register write-back stage: default widths,
// the hardwired-zero register address and the pending-write entry layout.
package reg_writeback_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam logic [DEF_ADDR_WIDTH-1:0] R0_ADDR = '0;

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: in-order pending-write queue with up to two pushes and one pop per
// cycle; presents its contents oldest-first for hazard comparison.
module wb_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pop,
    input  logic                                push0_valid,
    input  logic [ADDR_WIDTH-1:0]               push0_addr,
    input  logic [DATA_WIDTH-1:0]               push0_data,
    input  logic                                push1_valid,
    input  logic [ADDR_WIDTH-1:0]               push1_addr,
    input  logic [DATA_WIDTH-1:0]               push1_data,
    output logic [CNT_W-1:0]                    count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    entry_addr,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]    entry_data
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    slot_t [DEPTH-1:0] mem_q, mem_d;
    logic  [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic  [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic  [CNT_W-1:0] count_q, count_d;

    // push1 lands in the slot after push0, so the second write reuses the
    // already-advanced pointer.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push0_valid) + CNT_W'(push1_valid) - CNT_W'(pop);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push0_valid) begin
            mem_d[wr_ptr_d] = '{addr: push0_addr, data: push0_data};
            wr_ptr_d        = wr_ptr_d + PTR_W'(1);
        end
        if (push1_valid) begin
            mem_d[wr_ptr_d] = '{addr: push1_addr, data: push1_data};
            wr_ptr_d        = wr_ptr_d + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left unreset; count gates every read, so
    // stale contents are never observed and the array stays plain flops/RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;

    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        entry_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(i) < count_q);
            entry_addr[i]  = mem_q[rd_ptr_q + PTR_W'(i)].addr;
            entry_data[i]  = mem_q[rd_ptr_q + PTR_W'(i)].data;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-back stage: merges MEM and ALU writes in order, drains one
// per cycle and flags pending-write hazards. WB_FORWARD_EN adds CHECKn_DATA.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MEM_VALID,
    output logic                  MEM_READY,
    input  logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    input  logic                  ALU_VALID,
    output logic                  ALU_READY,
    input  logic [ADDR_WIDTH-1:0] ALU_ADDRESS,
    input  logic [DATA_WIDTH-1:0] ALU_DATA,
    output logic                  WRITE_ENABLE,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
    output logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic [ADDR_WIDTH-1:0] CHECK1_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] CHECK2_ADDRESS,
    output logic                  CHECK1_HIT,
    output logic                  CHECK2_HIT,
    output logic                  BUSY
`ifdef WB_FORWARD_EN
   ,output logic [DATA_WIDTH-1:0] CHECK1_DATA,
    output logic [DATA_WIDTH-1:0] CHECK2_DATA
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SLOT_W = CNT_W + 1;
    localparam logic [SLOT_W-1:0]     SLOTS_MAX = SLOT_W'(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(R0_ADDR);

    logic [CNT_W-1:0]                      q_count;
    logic [FIFO_DEPTH-1:0]                 q_valid;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] q_addr;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] q_data;

    logic                  pop;
    logic                  push0_valid, push1_valid;
    logic [ADDR_WIDTH-1:0] push0_addr, push1_addr;
    logic [DATA_WIDTH-1:0] push0_data, push1_data;

    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [SLOT_W-1:0] slots;
    logic              mem_keep, alu_keep;

    wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .pop         (pop),
        .push0_valid (push0_valid),
        .push0_addr  (push0_addr),
        .push0_data  (push0_data),
        .push1_valid (push1_valid),
        .push1_addr  (push1_addr),
        .push1_data  (push1_data),
        .count       (q_count),
        .entry_valid (q_valid),
        .entry_addr  (q_addr),
        .entry_data  (q_data)
    );

    // The output register always drains, so one slot exists even when full.
    assign slots     = SLOTS_MAX - SLOT_W'(q_count);
    assign MEM_READY = (slots != '0);
    assign ALU_READY = (slots >= SLOT_W'(2)) || ((slots == SLOT_W'(1)) && !MEM_VALID);

    assign mem_keep = MEM_VALID && MEM_READY && (MEM_ADDRESS != ZERO_ADDR);
    assign alu_keep = ALU_VALID && ALU_READY && (ALU_ADDRESS != ZERO_ADDR);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pop         = 1'b0;
        push0_valid = 1'b0;
        push0_addr  = MEM_ADDRESS;
        push0_data  = MEM_DATA;
        push1_valid = 1'b0;
        push1_addr  = ALU_ADDRESS;
        push1_data  = ALU_DATA;
        if (q_count != '0) begin
            pop       = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = q_addr[0];
            wr_data_d = q_data[0];
            if (mem_keep) begin
                push0_valid = 1'b1;
                push1_valid = alu_keep;
            end else if (alu_keep) begin
                push0_valid = 1'b1;
                push0_addr  = ALU_ADDRESS;
                push0_data  = ALU_DATA;
            end
        end else if (mem_keep) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = MEM_ADDRESS;
            wr_data_d   = MEM_DATA;
            push0_valid = alu_keep;
            push0_addr  = ALU_ADDRESS;
            push0_data  = ALU_DATA;
        end else if (alu_keep) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ALU_ADDRESS;
            wr_data_d = ALU_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign WRITE_ENABLE  = wr_en_q;
    assign WRITE_ADDRESS = wr_addr_q;
    assign WRITE_DATA    = wr_data_q;
    assign BUSY          = wr_en_q || (q_count != '0);

    logic [1:0][ADDR_WIDTH-1:0] chk_addr;
    logic [1:0]                 chk_hit;

    assign chk_addr = {CHECK2_ADDRESS, CHECK1_ADDRESS};

    always_comb begin
        chk_hit = '0;
        for (int n = 0; n < 2; n++) begin
            if (chk_addr[n] != ZERO_ADDR) begin
                if (wr_en_q && (wr_addr_q == chk_addr[n])) begin
                    chk_hit[n] = 1'b1;
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (q_valid[i] && (q_addr[i] == chk_addr[n])) begin
                        chk_hit[n] = 1'b1;
                    end
                end
            end
        end
    end

    assign CHECK1_HIT = chk_hit[0];
    assign CHECK2_HIT = chk_hit[1];

`ifdef WB_FORWARD_EN
    logic [1:0][DATA_WIDTH-1:0] chk_data;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        chk_data = '0;
        for (int n = 0; n < 2; n++) begin
            if (chk_addr[n] != ZERO_ADDR) begin
                if (wr_en_q && (wr_addr_q == chk_addr[n])) begin
                    chk_data[n] = wr_data_q;
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (q_valid[i] && (q_addr[i] == chk_addr[n])) begin
                        chk_data[n] = q_data[i];
                    end
                end
            end
        end
    end

    assign CHECK1_DATA = chk_data[0];
    assign CHECK2_DATA = chk_data[1];
`else
    logic unused_q_data;
    assign unused_q_data = ^q_data;
`endif

endmodule
